// File: rtl/serdesphy_ana_loop_filter_pkg.sv
// -----------------------------------------------------------------------------
// serdesphy_ana_loop_filter_pkg
// Shared PLL definitions: lock FSM state encodings and the default gain and
// lock constants used by the loop filter and by the PLL top.
// -----------------------------------------------------------------------------
package serdesphy_ana_loop_filter_pkg;

   // Lock FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // Default filter gains and widths
   localparam int         DEF_CODE_W     = 8;
   localparam int         DEF_INT_W      = 16;
   localparam int         DEF_KI_SHIFT   = 4;
   localparam int         DEF_KP         = 2;
   localparam logic [7:0] DEF_RESET_CODE = 8'h80;

   // Default lock detector constants
   localparam int         DEF_LOCK_WIN   = 64;
   localparam int         DEF_LOCK_TOL   = 4;
   localparam int         DEF_LOCK_GOOD  = 4;

endpackage

// File: rtl/serdesphy_sync2.sv
// -----------------------------------------------------------------------------
// serdesphy_sync2
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset (clears both flops)
//   d_i  - asynchronous input level
//   q_o  - synchronised level, two edges after capture
// -----------------------------------------------------------------------------
module serdesphy_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/serdesphy_ana_loop_filter.sv
// -----------------------------------------------------------------------------
// serdesphy_ana_loop_filter
// Digital charge pump + proportional/integral loop filter behind the PFD,
// producing a saturating VCO control code and a windowed lock indicator.
// Ports:
//   clk        - filter clock
//   rst        - synchronous active-high reset
//   enable     - filter enable; low freezes the code and drops lock
//   up_pulse   - PFD UP request (asynchronous)
//   down_pulse - PFD DOWN request (asynchronous)
//   vctrl_code - registered VCO control code
//   sat_hi     - registered, code is all-ones
//   sat_lo     - registered, code is zero
//   lock       - registered lock indicator
// -----------------------------------------------------------------------------
module serdesphy_ana_loop_filter
   import serdesphy_ana_loop_filter_pkg::*;
#(
   parameter int                CODE_W     = DEF_CODE_W,
   parameter int                INT_W      = DEF_INT_W,
   parameter int                KI_SHIFT   = DEF_KI_SHIFT,
   parameter int                KP         = DEF_KP,
   parameter logic [CODE_W-1:0] RESET_CODE = CODE_W'(DEF_RESET_CODE),
   parameter int                LOCK_WIN   = DEF_LOCK_WIN,
   parameter int                LOCK_TOL   = DEF_LOCK_TOL,
   parameter int                LOCK_GOOD  = DEF_LOCK_GOOD
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              up_pulse,
   input  logic              down_pulse,
   output logic [CODE_W-1:0] vctrl_code,
   output logic              sat_hi,
   output logic              sat_lo,
   output logic              lock
);

   localparam int ACC_EXT_W  = INT_W + 2;
   localparam int CODE_EXT_W = CODE_W + 2;
   localparam int WIN_W      = $clog2(LOCK_WIN);
   localparam int ERR_W      = $clog2(LOCK_WIN + 1);
   localparam int GOOD_W     = $clog2(LOCK_GOOD + 1);

   localparam logic [INT_W-1:0]            ACC_RESET = {RESET_CODE, {(INT_W-CODE_W){1'b0}}};
   localparam logic signed [ACC_EXT_W-1:0] ACC_MAX   = ACC_EXT_W'({INT_W{1'b1}});
   localparam logic signed [CODE_EXT_W-1:0] CODE_MAX = CODE_EXT_W'({CODE_W{1'b1}});

   // Clamp the widened integrator sum into [0, 2^INT_W-1]
   function automatic logic [INT_W-1:0] sat_acc(input logic signed [ACC_EXT_W-1:0] v);
      if (v < 0)            sat_acc = '0;
      else if (v > ACC_MAX) sat_acc = '1;
      else                  sat_acc = v[INT_W-1:0];
   endfunction

   // Clamp the widened output code into [0, 2^CODE_W-1]
   function automatic logic [CODE_W-1:0] sat_code(input logic signed [CODE_EXT_W-1:0] v);
      if (v < 0)             sat_code = '0;
      else if (v > CODE_MAX) sat_code = '1;
      else                   sat_code = v[CODE_W-1:0];
   endfunction

   logic                          up_s, dn_s;
   logic signed [1:0]             err_e;
   logic                          err_active;
   logic signed [ACC_EXT_W-1:0]   acc_sum;
   logic signed [CODE_EXT_W-1:0]  kick, code_raw;
   logic [INT_W-1:0]              acc_q, acc_d;
   logic [CODE_W-1:0]             code_q, code_d;
   logic                          sat_hi_q, sat_lo_q, lock_q, lock_d;
   logic [1:0]                    state_q, state_d;
   logic [WIN_W-1:0]              win_q, win_d;
   logic [ERR_W-1:0]              errc_q, errc_d, err_total;
   logic [GOOD_W-1:0]             good_q, good_d, good_inc;
   logic                          win_end, win_good;

   // Stage boundary: asynchronous PFD levels into the clk domain
   serdesphy_sync2 u_sync_up (.clk(clk), .rst(rst), .d_i(up_pulse),   .q_o(up_s));
   serdesphy_sync2 u_sync_dn (.clk(clk), .rst(rst), .d_i(down_pulse), .q_o(dn_s));

   always_comb begin
      err_e = 2'sd0;
      if (enable && up_s && !dn_s)      err_e = 2'sd1;
      else if (enable && dn_s && !up_s) err_e = -2'sd1;
   end
   assign err_active = (err_e != 2'sd0);

   // Integral path uses the widened sum so over/underflow is seen before clamping
   assign acc_sum  = $signed({2'b00, acc_q}) + (ACC_EXT_W'(err_e) <<< KI_SHIFT);
   assign acc_d    = sat_acc(acc_sum);

   // Proportional kick rides on the current integrator MSBs, not the updated ones
   assign kick     = CODE_EXT_W'(err_e) * CODE_EXT_W'(KP);
   assign code_raw = $signed({2'b00, acc_q[INT_W-1 -: CODE_W]}) + kick;
   assign code_d   = sat_code(code_raw);

   // Lock detector: the current cycle's error is folded into the window verdict
   assign win_end   = (win_q == WIN_W'(LOCK_WIN - 1));
   assign err_total = errc_q + ERR_W'(err_active);
   assign win_good  = (err_total <= ERR_W'(LOCK_TOL));
   assign good_inc  = good_q + GOOD_W'(1);

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      errc_d  = errc_q;
      good_d  = good_q;
      if (!enable) begin
         state_d = ST_IDLE;
         win_d   = '0;
         errc_d  = '0;
         good_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQ;
               win_d   = '0;
               errc_d  = '0;
               good_d  = '0;
            end
            ST_ACQ, ST_LOCKED: begin
               if (win_end) begin
                  win_d  = '0;
                  errc_d = '0;
                  if (!win_good) begin
                     good_d  = '0;
                     state_d = ST_ACQ;
                  end else if (state_q == ST_ACQ) begin
                     good_d = good_inc;
                     if (good_inc == GOOD_W'(LOCK_GOOD)) state_d = ST_LOCKED;
                  end
               end else begin
                  win_d  = win_q + WIN_W'(1);
                  errc_d = err_total;
               end
            end
            default: begin
               state_d = ST_IDLE;
               win_d   = '0;
               errc_d  = '0;
               good_d  = '0;
            end
         endcase
      end
   end
   assign lock_d = (state_d == ST_LOCKED);

   // Stage boundary: integrator, output code and lock state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= ACC_RESET;
         code_q   <= RESET_CODE;
         sat_hi_q <= (RESET_CODE == '1);
         sat_lo_q <= (RESET_CODE == '0);
         state_q  <= ST_IDLE;
         win_q    <= '0;
         errc_q   <= '0;
         good_q   <= '0;
         lock_q   <= 1'b0;
      end else begin
         if (enable) begin
            acc_q    <= acc_d;
            code_q   <= code_d;
            sat_hi_q <= (code_d == '1);
            sat_lo_q <= (code_d == '0);
         end
         state_q <= state_d;
         win_q   <= win_d;
         errc_q  <= errc_d;
         good_q  <= good_d;
         lock_q  <= lock_d;
      end
   end

   assign vctrl_code = code_q;
   assign sat_hi     = sat_hi_q;
   assign sat_lo     = sat_lo_q;
   assign lock       = lock_q;

endmodule

// File: tb/tb_serdesphy_ana_loop_filter.sv
// -----------------------------------------------------------------------------
// tb_serdesphy_ana_loop_filter
// Self-checking bench: cycle-level arithmetic model of the filter and lock
// detector, compared with the DUT every cycle, plus literal checkpoints.
// -----------------------------------------------------------------------------
module tb_serdesphy_ana_loop_filter;

   logic       clk = 1'b0;
   logic       rst, enable, up_pulse, down_pulse;
   logic [7:0] vctrl_code;
   logic       sat_hi, sat_lo, lock;

   serdesphy_ana_loop_filter dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .up_pulse   (up_pulse),
      .down_pulse (down_pulse),
      .vctrl_code (vctrl_code),
      .sat_hi     (sat_hi),
      .sat_lo     (sat_lo),
      .lock       (lock)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_acc, m_code, m_sathi, m_satlo, m_lock;
   int m_u1, m_u2, m_d1, m_d2;
   int m_active, m_pos, m_errs, m_goods;
   bit m_valid = 1'b0;

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   always @(posedge clk) begin
      int e, old_top;
      if (rst) begin
         m_acc = 32'h8000; m_code = 8'h80; m_sathi = 0; m_satlo = 0; m_lock = 0;
         m_u1 = 0; m_u2 = 0; m_d1 = 0; m_d2 = 0;
         m_active = 0; m_pos = 0; m_errs = 0; m_goods = 0;
         m_valid = 1'b1;
      end else begin
         // UP-only gives +1, DOWN-only gives -1, both or neither 0
         e = enable ? (m_u2 - m_d2) : 0;
         if (enable) begin
            old_top = m_acc / 256;
            m_acc   = clampi(m_acc + e * 16, 0, 65535);
            m_code  = clampi(old_top + 2 * e, 0, 255);
            m_sathi = (m_code == 255);
            m_satlo = (m_code == 0);
         end
         if (!enable) begin
            m_active = 0; m_lock = 0; m_pos = 0; m_errs = 0; m_goods = 0;
         end else if (!m_active) begin
            m_active = 1; m_pos = 0; m_errs = 0; m_goods = 0;
         end else begin
            if (e != 0) m_errs++;
            if (m_pos == 63) begin
               if (m_errs <= 4) begin
                  if (!m_lock) begin
                     m_goods++;
                     if (m_goods == 4) m_lock = 1;
                  end
               end else begin
                  m_goods = 0;
                  m_lock  = 0;
               end
               m_pos = 0; m_errs = 0;
            end else begin
               m_pos++;
            end
         end
         m_u2 = m_u1; m_u1 = up_pulse;
         m_d2 = m_d1; m_d1 = down_pulse;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_code",   vctrl_code,  m_code);
         chk("cyc_acc",    dut.acc_q,   m_acc);
         chk("cyc_sat_hi", sat_hi,      m_sathi);
         chk("cyc_sat_lo", sat_lo,      m_satlo);
         chk("cyc_lock",   lock,        m_lock);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_lock(input logic val, input int limit, input string name);
      int i = 0;
      while (lock !== val && i < limit) begin
         step(1);
         i++;
      end
      chk(name, lock, val);
   endtask

   task automatic idle_noise(input int n);
      // occasional both-high cycles never count as errors
      for (int i = 0; i < n; i++) begin
         logic b;
         b = ($urandom_range(0, 3) == 0);
         up_pulse = b; down_pulse = b;
         step(1);
      end
      up_pulse = 1'b0; down_pulse = 1'b0;
   endtask

   int frozen;

   initial begin
      rst = 1'b1; enable = 1'b0; up_pulse = 1'b0; down_pulse = 1'b0;
      step(2);
      chk("rst_code",   vctrl_code, 8'h80);
      chk("rst_lock",   lock, 0);
      chk("rst_sat_hi", sat_hi, 0);
      chk("rst_sat_lo", sat_lo, 0);
      chk("rst_acc",    dut.acc_q, 16'h8000);

      // lock acquire with idle inputs
      rst = 1'b0; enable = 1'b1;
      step(256);
      chk("lock_before_4win", lock, 0);
      step(1);
      chk("lock_after_4win", lock, 1);

      // simultaneous UP and DOWN
      up_pulse = 1'b1; down_pulse = 1'b1;
      step(100);
      chk("simul_code", vctrl_code, 8'h80);
      chk("simul_lock", lock, 1);
      up_pulse = 1'b0; down_pulse = 1'b0;

      // 5 error cycles inside one window drop lock at its end
      up_pulse = 1'b1;
      step(5);
      up_pulse = 1'b0;
      wait_lock(1'b0, 100, "lock_loss");
      chk("loss_code", vctrl_code, 8'h80);

      // UP burst from a clean reset
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      up_pulse = 1'b1;
      step(3);
      chk("burst_first_kick", vctrl_code, 8'h82);
      step(14);
      up_pulse = 1'b0;
      step(1);
      chk("burst_code_8100", vctrl_code, 8'h82);
      chk("burst_acc_8100",  dut.acc_q, 16'h8100);
      step(1);
      chk("burst_code_83", vctrl_code, 8'h83);
      step(1);
      chk("burst_release", vctrl_code, 8'h81);
      chk("burst_acc_end", dut.acc_q, 16'h8110);

      // saturation high then low
      up_pulse = 1'b1;
      step(3000);
      chk("sat_acc_hi",  dut.acc_q, 16'hFFFF);
      chk("sat_code_hi", vctrl_code, 8'hFF);
      chk("sat_hi_flag", sat_hi, 1);
      up_pulse = 1'b0; down_pulse = 1'b1;
      step(5000);
      chk("sat_code_lo", vctrl_code, 8'h00);
      chk("sat_lo_flag", sat_lo, 1);
      chk("sat_acc_lo",  dut.acc_q, 0);
      down_pulse = 1'b0;
      step(3);

      // random PFD activity checked by the model only
      for (int i = 0; i < 600; i++) begin
         up_pulse   = ($urandom_range(0, 2) == 0);
         down_pulse = ($urandom_range(0, 2) == 0);
         step(1);
      end
      up_pulse = 1'b0; down_pulse = 1'b0;

      // drive the code to 0xA0 from a clean reset and relock
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      up_pulse = 1'b1;
      step(512);
      up_pulse = 1'b0;
      step(3);
      chk("a0_code", vctrl_code, 8'hA0);
      chk("a0_acc",  dut.acc_q, 16'hA000);
      idle_noise(40);
      wait_lock(1'b1, 400, "a0_relock");
      chk("a0_code_locked", vctrl_code, 8'hA0);

      // mid-operation reset while locked
      rst = 1'b1;
      step(1);
      chk("midrst_code",  vctrl_code, 8'h80);
      chk("midrst_lock",  lock, 0);
      chk("midrst_state", dut.state_q, 0);
      chk("midrst_acc",   dut.acc_q, 16'h8000);
      rst = 1'b0;

      // enable dropped during an UP burst
      wait_lock(1'b1, 300, "relock_after_rst");
      up_pulse = 1'b1;
      step(10);
      chk("pre_disable_lock", lock, 1);
      frozen = vctrl_code;
      enable = 1'b0;
      step(1);
      chk("disable_lock",   lock, 0);
      chk("disable_freeze", vctrl_code, frozen);
      step(5);
      up_pulse = 1'b0;
      step(5);
      chk("disable_hold", vctrl_code, frozen);
      enable = 1'b1;
      step(5);
      chk("reenable_lock", lock, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
